// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter slice.
// Holds the transmit FSM state encoding and the default frame parameters
// used by uart_transmitter and uart_baud_counter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 104;
  localparam int DATA_BITS_DEFAULT    = 8;
  localparam int STOP_BITS_DEFAULT    = 1;

  // Transmit FSM states, in frame order.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; bit_done is high for the single cycle
// in which the count sits at CLKS_PER_BIT-1, so the consumer acts on the
// edge that ends the bit period.
//
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  asynchronous active-high reset
//   clear    in  hold the count at zero (used while the transmitter is idle)
//   bit_done out one-cycle pulse on the last cycle of each bit period
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    // Gated by clear so a one-clock bit period cannot fire while idle.
    bit_done = !clear && (cnt_q == LAST);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// Asynchronous serial transmitter (8N1 by default, LSB first).
// A byte is accepted on a rising edge where start=1 while idle; the frame
// (start bit, DATA_BITS data bits, STOP_BITS stop bits) is then shifted
// out on tx, each bit lasting CLKS_PER_BIT clocks.
//
// Handshake: start is a level request sampled only in IDLE. in_progress
// is high from the accept edge until the edge ending the last stop bit;
// start seen while in_progress=1 (including the edge where it falls) is
// dropped, giving at least one idle-high clock between frames.
//
// Ports:
//   clk         in  system clock, rising edge
//   reset       in  asynchronous active-high reset (aborts any frame)
//   data        in  payload, latched on the accept edge only
//   start       in  transmit request
//   in_progress out busy flag, registered
//   tx          out serial line, idle high, registered (glitch-free)
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = DATA_BITS_DEFAULT,
  parameter int STOP_BITS    = STOP_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  output logic                 in_progress,
  output logic                 tx
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_done;

  // Held clear in IDLE so every frame's timing starts at the accept edge.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = START;
          shift_d   = data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_DATA) begin
            state_d   = STOP;
            tx_d      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        // bit_cnt_q is reused to count stop bits.
        if (bit_done) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign in_progress = busy_q;
  assign tx          = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter (default 8N1, 104 clocks/bit).
// The reference model lists the frame's line levels bit by bit in exp_q;
// the expected tx at j clocks after the accept edge is exp_q[j / C].
module tb_uart_transmitter;

  localparam int C  = 104;
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int F  = (1 + DB + SB) * C;
  localparam int NONE = -10;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic       in_progress;
  logic       tx;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  uart_transmitter #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .start      (start),
    .in_progress(in_progress),
    .tx         (tx)
  );

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Line levels of one frame: start bit, data LSB first, stop bits.
  task automatic build_frame(input logic [7:0] d);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) exp_q.push_back(d[i]);
    for (int i = 0; i < SB; i++) exp_q.push_back(1'b1);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requests a frame with payload d and follows it to edge k+F.
  // hold: number of edges (from the accept edge) start stays high, or <=0
  //   to leave it high. inj_at/inj_d: at j=inj_at raise start for one edge
  //   and change data, which must not disturb the frame in flight.
  task automatic run_frame(input logic [7:0] d, input int hold,
                           input int inj_at, input logic [7:0] inj_d,
                           input string tag);
    build_frame(d);
    data  = d;
    start = 1'b1;
    step();
    for (int j = 0; j <= F; j++) begin
      int ph;
      ph = j % C;
      if (j < F && (ph == 0 || ph == C - 1))
        check($sformatf("%s tx j=%0d", tag, j), tx, exp_q[j / C]);
      if (j == 0 || j == F - 1)
        check($sformatf("%s busy j=%0d", tag, j), in_progress, 1'b1);
      if (j == F) begin
        check({tag, " tx_end"}, tx, 1'b1);
        check({tag, " busy_end"}, in_progress, 1'b0);
      end
      if (hold > 0 && j == hold - 1) start = 1'b0;
      if (j == inj_at) begin
        data  = inj_d;
        start = 1'b1;
      end
      if (j == inj_at + 1) start = 1'b0;
      if (j < F) step();
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    #12;
    check("in_reset tx", tx, 1'b1);
    check("in_reset busy", in_progress, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("post_reset tx", tx, 1'b1);
    check("post_reset busy", in_progress, 1'b0);

    // 0x55, start held for two edges.
    run_frame(8'h55, 2, NONE, 8'h00, "f55");
    repeat (3) step();
    check("idle_after_55 tx", tx, 1'b1);
    check("idle_after_55 busy", in_progress, 1'b0);

    // 0xA5: data bits 1,0,1,0,0,1,0,1.
    run_frame(8'hA5, 1, NONE, 8'h00, "fA5");
    repeat (2) step();

    // Mid-frame start with new data at j=500 must be ignored.
    run_frame(8'h55, 1, 500, 8'hFF, "inj");
    step();
    check("inj_no_refire busy", in_progress, 1'b0);
    repeat (2) step();

    // start held high: back-to-back frames with one idle clock between.
    run_frame(8'h3C, 0, NONE, 8'h00, "b2b0");
    run_frame(8'h3C, 0, NONE, 8'h00, "b2b1");
    run_frame(8'h3C, 0, NONE, 8'h00, "b2b2");
    start = 1'b0;
    step();
    check("b2b_stop busy", in_progress, 1'b0);
    check("b2b_stop tx", tx, 1'b1);

    // start sampled on the edge in_progress falls is dropped.
    run_frame(8'h96, 1, F - 1, 8'h96, "edge");
    step();
    check("edge_ignored busy", in_progress, 1'b0);
    check("edge_ignored tx", tx, 1'b1);
    run_frame(8'h69, 1, NONE, 8'h00, "next");

    // Asynchronous reset in the middle of a frame.
    repeat (2) step();
    data  = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (300) step();
    check("pre_reset tx", tx, 1'b0);
    check("pre_reset busy", in_progress, 1'b1);
    reset = 1'b1;
    #2;
    check("async_reset tx", tx, 1'b1);
    check("async_reset busy", in_progress, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("after_abort busy", in_progress, 1'b0);
    run_frame(8'h5A, 1, NONE, 8'h00, "post_rst");

    // Random payloads, gaps, hold lengths and mid-frame interference.
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      logic [7:0] nd;
      int         gap;
      int         hold;
      int         inj;
      d    = 8'($urandom_range(0, 255));
      nd   = 8'($urandom_range(0, 255));
      gap  = $urandom_range(0, 5);
      hold = $urandom_range(1, 3);
      inj  = ($urandom_range(0, 1) == 1) ? $urandom_range(3, F - 1) : NONE;
      repeat (gap) step();
      run_frame(d, hold, inj, nd, $sformatf("rnd%0d_%02h", i, d));
      step();
      check($sformatf("rnd%0d idle", i), in_progress, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
